// File: rtl/ahb_arb_pkg.sv
// Shared encodings for the two-master AHB arbiter: HTRANS codes, master IDs
// and the one-hot grant state.
package ahb_arb_pkg;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    localparam int MST_NONE = 0;
    localparam int MST_M1   = 1;
    localparam int MST_M2   = 2;

    typedef enum logic [1:0] {
        GNT_M1 = 2'b01,
        GNT_M2 = 2'b10
    } gnt_state_t;

    // A data phase follows only NONSEQ and SEQ address phases.
    function automatic logic is_xfer(input logic [1:0] htrans);
        return (htrans == NONSEQ) || (htrans == SEQ);
    endfunction

endpackage

// File: rtl/ahb_bus_arbiter.sv
// Two-master AHB arbiter (M1 = instruction fetch / park master, M2 = data).
// Define ARB_FAIR_EN to stop M2 from starving M1 after FAIR_LIMIT transfers.
module ahb_bus_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int FAIR_LIMIT = 4,
    parameter int MASTER_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                HBUSREQ_M1,
    input  logic                HBUSREQ_M2,
    input  logic                HLOCK_M1,
    input  logic                HLOCK_M2,
    input  logic [1:0]          HTRANS,
    input  logic                HREADY,
    output logic                HGRANT_M1,
    output logic                HGRANT_M2,
    output logic [MASTER_W-1:0] HMASTER,
    output logic [MASTER_W-1:0] HMASTER_D,
    output logic                HMASTLOCK
);

    gnt_state_t          gnt_q;
    gnt_state_t          gnt_d;
    logic                owner_lock;
    logic                rearb;
    logic                fair_win;
    logic [MASTER_W-1:0] gnt_id;

    assign owner_lock = (gnt_q == GNT_M2) ? HLOCK_M2 : HLOCK_M1;
    assign gnt_id     = (gnt_q == GNT_M2) ? MASTER_W'(MST_M2) : MASTER_W'(MST_M1);

    // Never re-arbitrate in the middle of a burst or a locked sequence.
    assign rearb = HREADY && !owner_lock && (HTRANS != SEQ) && (HTRANS != BUSY);

`ifdef ARB_FAIR_EN
    localparam int CNT_W = (FAIR_LIMIT > 0) ? $clog2(FAIR_LIMIT + 1) : 1;

    logic [CNT_W-1:0] fair_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_W'(FAIR_LIMIT)) ? v : v + 1'b1;
    endfunction

    assign fair_win = rearb && HBUSREQ_M1 && (fair_cnt >= CNT_W'(FAIR_LIMIT));

    // Counts M2 transfers issued while M1 sits waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            fair_cnt <= '0;
        end else if (HREADY) begin
            if (!HBUSREQ_M1 || (gnt_q == GNT_M1) || fair_win)
                fair_cnt <= '0;
            else if ((HMASTER == MASTER_W'(MST_M2)) && is_xfer(HTRANS))
                fair_cnt <= sat_inc(fair_cnt);
        end
    end
`else
    logic unused_fair_limit;

    assign fair_win          = 1'b0;
    assign unused_fair_limit = (FAIR_LIMIT != 0);
`endif

    always_ff @(posedge clk) begin
        if (rst)
            gnt_q <= GNT_M1;
        else
            gnt_q <= gnt_d;
    end

    always_comb begin
        gnt_d = gnt_q;
        if (rearb) begin
            if (fair_win)
                gnt_d = GNT_M1;
            else if (HBUSREQ_M2)
                gnt_d = GNT_M2;
            else
                gnt_d = GNT_M1;
        end
    end

    assign HGRANT_M1 = (gnt_q == GNT_M1);
    assign HGRANT_M2 = (gnt_q == GNT_M2);

    // Address-phase owner follows the grant; data-phase owner trails by one
    // accepted address phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            HMASTER   <= MASTER_W'(MST_M1);
            HMASTER_D <= MASTER_W'(MST_NONE);
            HMASTLOCK <= 1'b0;
        end else if (HREADY) begin
            HMASTER   <= gnt_id;
            HMASTLOCK <= owner_lock;
            HMASTER_D <= is_xfer(HTRANS) ? HMASTER : MASTER_W'(MST_NONE);
        end
    end

endmodule
